// File: rtl/exwb_writeback_stage.sv
// EX/WB pipeline register plus 8-entry register file for the 8-bit core.
// The WB entry commits into the register file at the edge where it leaves
// EX/WB. Two read ports bypass a pending WB write, so ID always sees the
// youngest value of a register.
module exwb_writeback_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              ex_write_en,
  input  logic [ADDR_W-1:0] ex_write_reg,
  input  logic [DATA_W-1:0] ex_write_data,
  output logic              wb_write_en,
  output logic [ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [7:0]        commit_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              commitNow;
  logic              bypassA;
  logic              bypassB;

  // A pending entry commits when it leaves EX/WB: either the pipe advances
  // or a flush replaces it. A stall alone keeps it waiting.
  assign commitNow = wb_write_en & (~stall_i | flush_i);

  // EX/WB register: flush beats stall, stall holds, otherwise capture EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_write_en   <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end else if (flush_i) begin
      wb_write_en   <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end else if (!stall_i) begin
      wb_write_en   <= ex_write_en;
      wb_write_reg  <= ex_write_reg;
      wb_write_data <= ex_write_data;
    end
  end

  // Register file write on commit; r0 is an ordinary writable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commitNow) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  // Count committed writes; an 8-bit counter wraps naturally 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_count <= 8'd0;
    end else if (commitNow) begin
      commit_count <= commit_count + 8'd1;
    end
  end

  // Bypass hits depend only on the registered WB entry and the read address.
  assign bypassA = wb_write_en && (wb_write_reg == rd_addr_a);
  assign bypassB = wb_write_en && (wb_write_reg == rd_addr_b);

  // Read port A: a pending WB write to the same register wins over the file.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (bypassA) begin
      rd_data_a = wb_write_data;
    end
  end

  // Read port B: same bypass rule as port A.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (bypassB) begin
      rd_data_b = wb_write_data;
    end
  end

endmodule

// File: tb/tb_exwb_writeback_stage.sv
// Bench for exwb_writeback_stage: a directed vector table, reset and wrap
// sequences, and randomized traffic against a behavioural model.
module tb_exwb_writeback_stage;

  logic       clk;
  logic       rst_n;
  logic       stall_i;
  logic       flush_i;
  logic       ex_write_en;
  logic [2:0] ex_write_reg;
  logic [7:0] ex_write_data;
  logic       wb_write_en;
  logic [2:0] wb_write_reg;
  logic [7:0] wb_write_data;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [7:0] commit_count;

  int errors;
  int checks;

  // Behavioural model: one pending write slot, a register array, a count.
  logic       mPendValid;
  logic [2:0] mPendReg;
  logic [7:0] mPendData;
  logic [7:0] mRegs [8];
  int         mCount;

  typedef struct {
    logic       stall;
    logic       flush;
    logic       en;
    logic [2:0] wreg;
    logic [7:0] wdata;
    logic [2:0] rdA;
    logic [2:0] rdB;
    logic       expEn;
    logic [2:0] expReg;
    logic [7:0] expData;
    logic [7:0] expRdA;
    logic [7:0] expRdB;
    logic [7:0] expCount;
  } vec_t;

  vec_t vecs [14];

  exwb_writeback_stage #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ex_write_en  (ex_write_en),
    .ex_write_reg (ex_write_reg),
    .ex_write_data(ex_write_data),
    .wb_write_en  (wb_write_en),
    .wb_write_reg (wb_write_reg),
    .wb_write_data(wb_write_data),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic st, input logic fl, input logic en, input logic [2:0] wr,
    input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
    input logic xEn, input logic [2:0] xReg, input logic [7:0] xData,
    input logic [7:0] xA, input logic [7:0] xB, input logic [7:0] xCnt);
    vec_t v;
    v.stall = st;    v.flush = fl;    v.en = en;
    v.wreg = wr;     v.wdata = wd;    v.rdA = ra;    v.rdB = rb;
    v.expEn = xEn;   v.expReg = xReg; v.expData = xData;
    v.expRdA = xA;   v.expRdB = xB;   v.expCount = xCnt;
    return v;
  endfunction

  function automatic logic [7:0] modelRead(input logic [2:0] addr);
    if (mPendValid && mPendReg == addr) return mPendData;
    return mRegs[addr];
  endfunction

  task automatic modelReset();
    mPendValid = 1'b0;
    mPendReg   = 3'd0;
    mPendData  = 8'd0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'd0;
    mCount = 0;
  endtask

  // The entry leaves the slot on an advance or a flush, and is written then.
  task automatic modelEdge();
    logic leaving;
    leaving = !stall_i || flush_i;
    if (mPendValid && leaving) begin
      mRegs[mPendReg] = mPendData;
      mCount = (mCount + 1) % 256;
    end
    if (flush_i) begin
      mPendValid = 1'b0;
      mPendReg   = 3'd0;
      mPendData  = 8'd0;
    end else if (!stall_i) begin
      mPendValid = ex_write_en;
      mPendReg   = ex_write_reg;
      mPendData  = ex_write_data;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic en,
                               input logic [2:0] wr, input logic [7:0] wd,
                               input logic [2:0] ra, input logic [2:0] rb);
    stall_i       = st;
    flush_i       = fl;
    ex_write_en   = en;
    ex_write_reg  = wr;
    ex_write_data = wd;
    rd_addr_a     = ra;
    rd_addr_b     = rb;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".wbEn"},   32'(wb_write_en),   32'(mPendValid));
    checkOutput({tag, ".wbReg"},  32'(wb_write_reg),  32'(mPendReg));
    checkOutput({tag, ".wbData"}, 32'(wb_write_data), 32'(mPendData));
    checkOutput({tag, ".rdA"},    32'(rd_data_a),     32'(modelRead(rd_addr_a)));
    checkOutput({tag, ".rdB"},    32'(rd_data_b),     32'(modelRead(rd_addr_b)));
    checkOutput({tag, ".count"},  32'(commit_count),  32'(mCount));
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst.wbEn",   32'(wb_write_en),   32'd0);
    checkOutput("rst.wbReg",  32'(wb_write_reg),  32'd0);
    checkOutput("rst.wbData", 32'(wb_write_data), 32'd0);
    checkOutput("rst.count",  32'(commit_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 3'd0, 8'h00, 3'd5, 3'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("init.wbEn",  32'(wb_write_en),  32'd0);
    checkOutput("init.count", 32'(commit_count), 32'd0);
    checkOutput("init.rdA",   32'(rd_data_a),    32'd0);
    checkOutput("init.rdB",   32'(rd_data_b),    32'd0);

    // Directed table: stall, flush, en, reg, data, rdA, rdB,
    // then expected wbEn, wbReg, wbData, rdDataA, rdDataB, count after the edge.
    vecs[0]  = mkVec(0,0,1,3'd3,8'hA5, 3'd3,3'd0, 1,3'd3,8'hA5, 8'hA5,8'h00,8'd0);
    vecs[1]  = mkVec(0,0,0,3'd0,8'h00, 3'd3,3'd2, 0,3'd0,8'h00, 8'hA5,8'h00,8'd1);
    vecs[2]  = mkVec(0,0,1,3'd2,8'h11, 3'd3,3'd2, 1,3'd2,8'h11, 8'hA5,8'h11,8'd1);
    vecs[3]  = mkVec(0,0,1,3'd2,8'h22, 3'd3,3'd2, 1,3'd2,8'h22, 8'hA5,8'h22,8'd2);
    vecs[4]  = mkVec(0,0,1,3'd4,8'h7E, 3'd4,3'd2, 1,3'd4,8'h7E, 8'h7E,8'h22,8'd3);
    vecs[5]  = mkVec(1,0,1,3'd1,8'hFF, 3'd4,3'd2, 1,3'd4,8'h7E, 8'h7E,8'h22,8'd3);
    vecs[6]  = mkVec(1,0,1,3'd1,8'hFF, 3'd4,3'd2, 1,3'd4,8'h7E, 8'h7E,8'h22,8'd3);
    vecs[7]  = mkVec(1,0,1,3'd1,8'hFF, 3'd4,3'd2, 1,3'd4,8'h7E, 8'h7E,8'h22,8'd3);
    vecs[8]  = mkVec(0,0,0,3'd0,8'h00, 3'd4,3'd1, 0,3'd0,8'h00, 8'h7E,8'h00,8'd4);
    vecs[9]  = mkVec(0,0,1,3'd6,8'h99, 3'd6,3'd4, 1,3'd6,8'h99, 8'h99,8'h7E,8'd4);
    vecs[10] = mkVec(1,1,1,3'd5,8'h55, 3'd6,3'd5, 0,3'd0,8'h00, 8'h99,8'h00,8'd5);
    vecs[11] = mkVec(0,1,1,3'd7,8'hAA, 3'd6,3'd7, 0,3'd0,8'h00, 8'h99,8'h00,8'd5);
    vecs[12] = mkVec(0,0,1,3'd0,8'hC3, 3'd0,3'd6, 1,3'd0,8'hC3, 8'hC3,8'h99,8'd5);
    vecs[13] = mkVec(0,0,0,3'd7,8'hEE, 3'd0,3'd7, 0,3'd7,8'hEE, 8'hC3,8'h00,8'd6);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].en, vecs[i].wreg,
                    vecs[i].wdata, vecs[i].rdA, vecs[i].rdB);
      tick();
      checkOutput($sformatf("vec%0d.wbEn", i),   32'(wb_write_en),   32'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d.wbReg", i),  32'(wb_write_reg),  32'(vecs[i].expReg));
      checkOutput($sformatf("vec%0d.wbData", i), 32'(wb_write_data), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d.rdA", i),    32'(rd_data_a),     32'(vecs[i].expRdA));
      checkOutput($sformatf("vec%0d.rdB", i),    32'(rd_data_b),     32'(vecs[i].expRdB));
      checkOutput($sformatf("vec%0d.count", i),  32'(commit_count),  32'(vecs[i].expCount));
    end

    // Reset while a write to r5 is pending: it must be discarded.
    applyStimulus(0, 0, 1, 3'd5, 8'h3C, 3'd5, 3'd0);
    tick();
    checkOutput("preRst.wbEn", 32'(wb_write_en), 32'd1);
    checkOutput("preRst.rdA",  32'(rd_data_a),   32'h3C);
    applyStimulus(0, 0, 0, 3'd0, 8'h00, 3'd5, 3'd3);
    doReset();
    checkOutput("postRst.rdA5",  32'(rd_data_a),    32'h00);
    checkOutput("postRst.rdB3",  32'(rd_data_b),    32'h00);
    checkOutput("postRst.count", 32'(commit_count), 32'd0);
    modelEdge();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(3) == 0), ($urandom_range(7) == 0),
                    1'($urandom_range(1)), 3'($urandom_range(7)),
                    8'($urandom_range(255)), 3'($urandom_range(7)),
                    3'($urandom_range(7)));
      tick();
      checkAgainstModel($sformatf("rand%0d", i));
    end

    // Counter wrap: 256 commits bring the count back to zero.
    applyStimulus(0, 0, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    doReset();
    modelEdge();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, 1, 3'($urandom_range(7)), 8'($urandom_range(255)),
                    3'($urandom_range(7)), 3'($urandom_range(7)));
      tick();
    end
    checkOutput("wrap.count255", 32'(commit_count), 32'd255);
    checkAgainstModel("wrap255");
    applyStimulus(0, 0, 0, 3'd0, 8'h00, 3'd1, 3'd2);
    tick();
    checkOutput("wrap.count0", 32'(commit_count), 32'd0);
    checkAgainstModel("wrap0");

    // Flush with nothing pending must not commit.
    applyStimulus(0, 1, 1, 3'd3, 8'h5A, 3'd3, 3'd1);
    tick();
    checkOutput("idleFlush.count", 32'(commit_count), 32'd0);
    checkOutput("idleFlush.wbEn",  32'(wb_write_en),  32'd0);
    checkAgainstModel("idleFlush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exwb_writeback_stage.md
# exwb_writeback_stage

EX/WB pipeline register and 8-entry × 8-bit register file for the 8-bit pipelined core.
- Captures the EX-stage result, holds it for one write-back cycle and commits it to the register file.
- Drives the write-back register/enable/data triple consumed by the operand forwarding mux.
- Provides two ID-stage read ports with same-cycle write-through bypass.

## Interface
- DATA_W, 8, register and data width
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W = 8 entries
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall_i  input  1  hold EX/WB contents; suppress commit
- flush_i  input  1  load a bubble into EX/WB at the next edge
- ex_write_en  input  1  EX-stage instruction writes a register
- ex_write_reg  input  ADDR_W  EX-stage destination register
- ex_write_data  input  DATA_W  EX-stage result
- wb_write_en  output  1  registered; WB-stage write valid (to forwarding)
- wb_write_reg  output  ADDR_W  registered WB destination
- wb_write_data  output  DATA_W  registered WB data
- rd_addr_a, rd_addr_b  input  ADDR_W  ID-stage read addresses
- rd_data_a, rd_data_b  output  DATA_W  combinational read data, bypassed
- commit_count  output  8  registered count of committed writes, wraps 255→0

## Operation
- EX/WB register update at each rising edge, in priority order:
  - flush_i=1: wb_write_en←0, wb_write_reg←0, wb_write_data←0. Flush overrides stall.
  - stall_i=1: hold all three wb_* outputs.
  - Otherwise: load ex_write_en, ex_write_reg and ex_write_data.
- Commit condition: commit = wb_write_en & (~stall_i | flush_i).
  - On commit, at the rising edge: regs[wb_write_reg] ← wb_write_data and commit_count ← commit_count + 1 (mod 256).
  - A WB entry therefore commits exactly once, at the edge where it leaves EX/WB.
  - During stall+flush, the WB entry commits before being replaced by the bubble. No write is lost.
- All 8 registers are writable; r0 is not hardwired.
- Read ports (rd_data_a; rd_data_b identical):
  - If wb_write_en=1 and wb_write_reg==rd_addr_a, rd_data_a = wb_write_data.
  - Otherwise rd_data_a = regs[rd_addr_a].
  - Bypass is active while stalled, because the entry is still pending.
- ex_write_reg and ex_write_data are don't-care when ex_write_en=0, but are still captured as given.

## Timing
- Reset (async assert, release synchronous to clk): wb_write_en=0, wb_write_reg=0, wb_write_data=0, all regs=0, commit_count=0. rd_data_a/b read 0.
- Reset asserted mid-operation discards the pending WB entry without committing it.
- Latency:
  - EX inputs at edge N appear on wb_* after edge N.
  - Register file is updated at edge N+1, if not stalled.
  - The read port shows the new value combinationally from just after edge N, via bypass, and from the regfile after edge N+1.
- Back-to-back writes to the same register commit in order; the read port always shows the youngest value.
- No combinational path from stall_i/flush_i to any output.
- Read ports are the only combinational outputs. Their path is addr → compare/mux → data.

## Test plan
- Reset: drive rst_n=0 mid-run with wb_write_en=1, reg 5, data 0x3C. Required response:
  - All outputs read 0.
  - After release, rd_addr_a=5 → 0x00.
  - commit_count=0.
- Basic write/bypass:
  - Stimulus: ex_write_en=1, reg 3, data 0xA5 at edge N; rd_addr_a=3.
  - After edge N: wb_write_reg=3, rd_data_a=0xA5 via bypass.
  - After edge N+1: regs[3]=0xA5, commit_count=1.
- Back-to-back writes to reg 2 (0x11 then 0x22) with rd_addr_b=2:
  - rd_data_b reads 0x11 then 0x22.
  - Final regs[2]=0x22, commit_count+=2.
- Stall:
  - Stimulus: WB holds reg 4 data 0x7E; stall_i=1 for 3 edges.
  - wb_* unchanged, regs[4] unchanged, rd_data_a(4)=0x7E, commit_count unchanged.
  - On release: exactly one commit.
- Stall+flush simultaneously with WB = reg 6 data 0x99: after the edge, regs[6]=0x99, wb_write_en=0, commit_count+=1.
- Wrap: 256 committed writes → commit_count returns to 0. Also confirm that a flush alone with wb_write_en=0 commits nothing.
